// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled on Clk, one-word transmit holding buffer,
// received words presented on RxData with a one-cycle RxValid strobe.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | Cs_n high; Miso held low, Sck edges ignored
// S_ACTIVE | Cs_n low; shifting words in and out on Sck
module spi_slave #(
  parameter int SPI_LEN = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Sck,
  input  logic               Cs_n,
  input  logic               Mosi,
  output logic               Miso,
  output logic               MisoOe,
  input  logic [SPI_LEN-1:0] TxData,
  input  logic               TxLoad,
  output logic               TxReady,
  output logic [SPI_LEN-1:0] RxData,
  output logic               RxValid,
  output logic               Underrun
);

  localparam int CW = $clog2(SPI_LEN);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t r_state, w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;

  logic [SPI_LEN-1:0] r_tx_sr, r_rx_sr, r_tx_buf, r_rx_data;
  logic [CW-1:0]      r_bit_cnt;
  logic               r_buf_full, r_seen_rise, r_load_pend;
  logic               r_rx_valid, r_underrun;

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_rise_ev, w_fall_ev, w_load, w_last;
  logic [SPI_LEN-1:0] w_rx_next;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_s3  <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= Sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_cs_s1   <= Cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= Mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall = ~r_sck_s2 & r_sck_s3;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_s3;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;

  // A deselect wins over any Sck edge seen in the same cycle.
  assign w_rise_ev = (r_state == S_ACTIVE) && !w_cs_rise && w_sck_rise;
  assign w_fall_ev = (r_state == S_ACTIVE) && !w_cs_rise && w_sck_fall && r_seen_rise;
  assign w_load    = ((r_state == S_IDLE) && w_cs_fall) || (w_fall_ev && r_load_pend);
  assign w_last    = (r_bit_cnt == CW'(SPI_LEN - 1));
  assign w_rx_next = {r_rx_sr[SPI_LEN-2:0], r_mosi_s2};

  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_cs_rise) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Miso   = 1'b0;
    MisoOe = 1'b0;
    if (r_state == S_ACTIVE) begin
      Miso   = r_tx_sr[SPI_LEN-1];
      MisoOe = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_tx_buf    <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_buf_full  <= 1'b0;
      r_seen_rise <= 1'b0;
      r_load_pend <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      // An empty buffer at a load sends zeros for the whole word.
      if (w_load) begin
        r_tx_sr    <= r_buf_full ? r_tx_buf : '0;
        r_underrun <= !r_buf_full;
      end else if (w_fall_ev) begin
        r_tx_sr <= {r_tx_sr[SPI_LEN-2:0], 1'b0};
      end

      // A write landing with a load refills the buffer for the following word.
      if (TxLoad && !r_buf_full) begin
        r_tx_buf   <= TxData;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end

      if ((r_state == S_IDLE) && w_cs_fall) begin
        r_bit_cnt   <= '0;
        r_rx_sr     <= '0;
        r_seen_rise <= 1'b0;
        r_load_pend <= 1'b0;
      end else if ((r_state == S_ACTIVE) && w_cs_rise) begin
        r_bit_cnt   <= '0;
        r_seen_rise <= 1'b0;
        r_load_pend <= 1'b0;
      end else if (w_rise_ev) begin
        r_rx_sr     <= w_rx_next;
        r_seen_rise <= 1'b1;
        if (w_last) begin
          r_bit_cnt   <= '0;
          r_rx_data   <= w_rx_next;
          r_rx_valid  <= 1'b1;
          r_load_pend <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (w_fall_ev && r_load_pend) begin
        r_load_pend <= 1'b0;
      end
    end
  end

  assign TxReady  = ~r_buf_full;
  assign RxData   = r_rx_data;
  assign RxValid  = r_rx_valid;
  assign Underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged mode-0 master, hand-computed
// Miso/RxData expectations, pulse counters sampled on the falling Clk edge.
module tb_spi_slave;

  localparam int HALF = 6;

  logic       Clk = 1'b0;
  logic       Rst, Sck, Cs_n, Mosi, TxLoad;
  logic [7:0] TxData;
  logic       Miso, MisoOe, TxReady, RxValid, Underrun;
  logic [7:0] RxData;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rxv = 0, n_udr = 0, n_rdy_rise = 0;
  int b_rxv, b_udr, b_rdy;
  logic       rdy_prev = 1'b1;
  logic [7:0] mi;

  spi_slave #(.SPI_LEN(8)) dut (
    .Clk(Clk), .Rst(Rst), .Sck(Sck), .Cs_n(Cs_n), .Mosi(Mosi),
    .Miso(Miso), .MisoOe(MisoOe), .TxData(TxData), .TxLoad(TxLoad),
    .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .Underrun(Underrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (RxValid)  n_rxv++;
    if (Underrun) n_udr++;
    if (TxReady && !rdy_prev) n_rdy_rise++;
    rdy_prev = TxReady;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rxv = n_rxv;
    b_udr = n_udr;
    b_rdy = n_rdy_rise;
  endtask

  task automatic tx_load(input logic [7:0] v);
    @(negedge Clk);
    TxData = v;
    TxLoad = 1'b1;
    @(negedge Clk);
    TxLoad = 1'b0;
  endtask

  task automatic cs_low();
    Cs_n = 1'b0;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic cs_high();
    Cs_n = 1'b1;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] so);
    so = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      Mosi = mo[i];
      repeat (HALF) @(negedge Clk);
      so[i] = Miso;
      Sck = 1'b1;
      repeat (HALF) @(negedge Clk);
      Sck = 1'b0;
    end
    repeat (HALF) @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b0; Sck = 1'b0; Cs_n = 1'b1; Mosi = 1'b0; TxLoad = 1'b0; TxData = '0;
    repeat (4) @(negedge Clk);
    chk("rst_miso",    Miso,    0);
    chk("rst_misooe",  MisoOe,  0);
    chk("rst_txready", TxReady, 1);
    chk("rst_rxdata",  RxData,  0);
    chk("rst_rxvalid", RxValid, 0);
    chk("rst_underrun", Underrun, 0);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);

    // Single word; the 0x55 write is dropped because the buffer is full.
    tx_load(8'hA5);
    chk("load_txready_low", TxReady, 0);
    tx_load(8'h55);
    snap();
    cs_low();
    chk("sel_misooe", MisoOe, 1);
    chk("sel_txready", TxReady, 1);
    tx_load(8'h99);  // keeps the end-of-word reload from underrunning
    xfer(8'h3C, 8, mi);
    chk("w1_miso", mi, 8'hA5);
    chk("w1_rxdata", RxData, 8'h3C);
    chk("w1_rxvalid_cnt", n_rxv - b_rxv, 1);
    chk("w1_underrun_cnt", n_udr - b_udr, 0);
    cs_high();
    chk("w1_desel_misooe", MisoOe, 0);
    chk("w1_desel_miso", Miso, 0);

    // Back-to-back words in one frame.
    tx_load(8'h81);
    snap();
    cs_low();
    tx_load(8'h7E);
    xfer(8'h12, 8, mi);
    chk("b2b_miso0", mi, 8'h81);
    chk("b2b_rx0", RxData, 8'h12);
    xfer(8'h34, 8, mi);
    chk("b2b_miso1", mi, 8'h7E);
    chk("b2b_rx1", RxData, 8'h34);
    chk("b2b_rxvalid_cnt", n_rxv - b_rxv, 2);
    chk("b2b_txready_rises", n_rdy_rise - b_rdy, 2);
    chk("b2b_underrun_cnt", n_udr - b_udr, 1);
    cs_high();

    // Empty buffer at select.
    snap();
    cs_low();
    chk("udr_at_sel", n_udr - b_udr, 1);
    xfer(8'hC3, 8, mi);
    chk("udr_miso", mi, 8'h00);
    chk("udr_rxdata", RxData, 8'hC3);
    chk("udr_underrun_cnt", n_udr - b_udr, 2);
    cs_high();

    // Deselect after 5 bits, then a clean full word.
    tx_load(8'hF0);
    snap();
    cs_low();
    xfer(8'hE7, 5, mi);
    cs_high();
    chk("part_rxvalid_cnt", n_rxv - b_rxv, 0);
    chk("part_misooe", MisoOe, 0);
    chk("part_rxdata_kept", RxData, 8'hC3);
    tx_load(8'h5A);
    cs_low();
    xfer(8'h96, 8, mi);
    chk("part_next_miso", mi, 8'h5A);
    chk("part_next_rxdata", RxData, 8'h96);
    chk("part_next_rxvalid_cnt", n_rxv - b_rxv, 1);
    cs_high();

    // Reset mid-word.
    tx_load(8'h11);
    cs_low();
    xfer(8'hAA, 3, mi);
    Rst = 1'b0;
    Cs_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mrst_miso", Miso, 0);
    chk("mrst_misooe", MisoOe, 0);
    chk("mrst_txready", TxReady, 1);
    chk("mrst_rxdata", RxData, 0);
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    chk("mrst_rel_misooe", MisoOe, 0);
    snap();
    cs_low();
    xfer(8'hFF, 8, mi);
    chk("mrst_ff_rxdata", RxData, 8'hFF);
    chk("mrst_ff_miso", mi, 8'h00);
    chk("mrst_ff_rxvalid_cnt", n_rxv - b_rxv, 1);
    cs_high();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SPI_LEN, default 8, meaning the word length in bits (range 2..16).
REQ-002 SHALL have Clk, input, 1, system clock; all logic on posedge Clk.
REQ-003 SHALL have Rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have Sck, input, 1, external SPI clock, asynchronous to Clk.
REQ-005 SHALL have Cs_n, input, 1, external chip select, active-low, asynchronous.
REQ-006 SHALL have Mosi, input, 1, external serial data in, asynchronous.
REQ-007 SHALL have Miso, output, 1, serial data out.
REQ-008 SHALL have MisoOe, output, 1, Miso output enable; high while selected.
REQ-009 SHALL have TxData, input, SPI_LEN, word to transmit.
REQ-010 SHALL have TxLoad, input, 1, write strobe capturing TxData into the holding buffer.
REQ-011 SHALL have TxReady, output, 1, holding buffer empty.
REQ-012 SHALL have RxData, output, SPI_LEN, last complete received word.
REQ-013 SHALL have RxValid, output, 1, one-cycle pulse when RxData updates.
REQ-014 SHALL have Underrun, output, 1, one-cycle pulse when a word starts with an empty buffer.

Function
REQ-015 SHALL use SPI mode 0: MSB first; Mosi sampled on Sck rising, Miso changes on Sck falling.
REQ-016 SHALL pass Sck, Cs_n and Mosi each through a 2-flop synchronizer, then detect edges by comparing against a third registered copy.
REQ-017 SHALL update state in the Clk cycle after an edge is detected, giving a fixed 3-Clk pin-to-output latency; Sck high and low phases each SHALL be >= 4 Clk periods.
REQ-018 SHALL implement two states: IDLE (Cs_n high) and ACTIVE (Cs_n low).
REQ-019 IDLE->ACTIVE on synchronized Cs_n falling: bit count = 0; tx shift register loaded from the holding buffer; TxReady = 1.
REQ-020 ACTIVE->IDLE on synchronized Cs_n rising.
REQ-021 Miso SHALL equal tx shift register bit SPI_LEN-1 in ACTIVE, and 0 in IDLE; MisoOe = 1 in ACTIVE only.
REQ-022 On each Sck rising in ACTIVE: shift synchronized Mosi into the rx shift register LSB; increment the bit count.
REQ-023 On the rising edge that completes bit SPI_LEN: RxData = assembled word; RxValid pulses for 1 cycle; bit count wraps to 0; load-pending is set.
REQ-024 On Sck falling in ACTIVE: if load-pending, load the tx shift register from the holding buffer, set TxReady = 1, and clear load-pending; otherwise shift left by 1, filling with 0.
REQ-025 SHALL ignore Sck falling edges before the first rising edge of a transfer.
REQ-026 SHALL capture TxData into the buffer on TxLoad && TxReady, then drop TxReady next cycle; TxLoad while TxReady = 0 SHALL be ignored.
REQ-027 If the buffer is empty at a load (REQ-019/024), SHALL load all-zero and pulse Underrun.
REQ-028 If TxLoad coincides with a load: the load consumes the old buffer contents (or zeros, per REQ-027); TxData is captured into the buffer for the next word.
REQ-029 Cs_n rising mid-word SHALL discard the partial word: no RxValid, bit count = 0, load-pending cleared, buffer contents kept.
REQ-030 Sck edges in IDLE SHALL have no effect.

Reset
REQ-031 While Rst = 0 at posedge Clk: state IDLE; shift registers, RxData and bit count = 0; Miso = 0; MisoOe = 0; RxValid = 0; Underrun = 0; TxReady = 1; synchronizers set to Sck = 0, Cs_n = 1.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer; after release, the block SHALL wait for a new Cs_n falling edge.

Verification
REQ-033 Load 0xA5; Cs_n low; master sends 0x3C -> Miso bits 1,0,1,0,0,1,0,1; RxData = 0x3C; one RxValid; no Underrun.
REQ-034 Two back-to-back words in one Cs_n frame; buffer 0x81 and then 0x7E loaded while TxReady = 1 -> Miso 0x81 then 0x7E; RxValid twice; TxReady rises at each load.
REQ-035 Cs_n low with the buffer empty -> Underrun pulse; Miso all zero for the word; RxData still captured.
REQ-036 Cs_n rising after 5 bits -> no RxValid; MisoOe = 0; the next frame receives a full fresh word correctly.
REQ-037 Rst low mid-word, then a new frame sending 0xFF -> all outputs at reset values; then RxData = 0xFF.
REQ-038 TxLoad while TxReady = 0 with 0x55 -> ignored; the buffer keeps its earlier value.
